// File: rtl/input_conditioner.sv
// Multi-channel input front end: per-channel synchronizer chain, counter debouncer,
// and registered single-cycle rise/fall strobes on each accepted level change.
module input_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_p0 [SYNC_STAGES];
    logic [CHANNELS-1:0] s;
    logic [CNT_W-1:0]    cnt [CHANNELS];

    // Stage: synchronizer chain, all channels side by side
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_p0[k] <= '0;
            end
        end else begin
            sync_p0[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_p0[k] <= sync_p0[k-1];
            end
        end
    end

    assign s = sync_p0[SYNC_STAGES-1];

    // Stage: debounce counter, accepted level and strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (s[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] == CNT_MAX) begin
                        // Mismatch persisted for the full window: accept it
                        level[i] <= s[i];
                        rise[i]  <= s[i];
                        fall[i]  <= ~s[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a behavioural model predicts each
// cycle's outputs into a queue, a monitor pops and compares after every edge.
module tb_input_conditioner;

    localparam int CH = 4;
    localparam int SS = 3;
    localparam int DB = 8;

    typedef struct packed {
        logic [CH-1:0] level;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick = 1'b0;
    logic [CH-1:0] din = '0;
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // Reference model: delay line of raw input samples plus, per channel,
    // how many qualifying ticks the synchronized value has disagreed with level.
    logic [CH-1:0] pipe[$];
    logic [CH-1:0] m_level = '0;
    logic [CH-1:0] m_rise  = '0;
    logic [CH-1:0] m_fall  = '0;
    int            run [CH];

    input_conditioner #(
        .CHANNELS(CH),
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .din(din),
        .level(level),
        .rise(rise),
        .fall(fall)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic [CH-1:0] d, input logic t, input logic r);
        logic [CH-1:0] sv;
        if (!r) begin
            pipe.delete();
            for (int k = 0; k < SS; k++) pipe.push_back('0);
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
            for (int c = 0; c < CH; c++) run[c] = 0;
        end else begin
            sv = pipe[SS-1];
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < CH; c++) begin
                if (sv[c] == m_level[c]) begin
                    run[c] = 0;
                end else if (t) begin
                    run[c] = run[c] + 1;
                    if (run[c] == DB) begin
                        m_level[c] = sv[c];
                        if (sv[c]) m_rise[c] = 1'b1;
                        else       m_fall[c] = 1'b1;
                        run[c] = 0;
                    end
                end
            end
            void'(pipe.pop_back());
            pipe.push_front(d);
        end
    endtask

    task automatic cycle(input logic [CH-1:0] d, input logic t, input logic r);
        exp_t e;
        @(negedge clk);
        din  = d;
        tick = t;
        rst  = r;
        model_step(d, t, r);
        e.level = m_level;
        e.rise  = m_rise;
        e.fall  = m_fall;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [CH-1:0] d, input logic t, input int n);
        for (int k = 0; k < n; k++) cycle(d, t, 1'b1);
    endtask

    // Monitor: one expected entry per edge
    initial begin
        exp_t e;
        int   ncyc;
        ncyc = 0;
        forever begin
            @(posedge clk);
            #1;
            ncyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (level !== e.level) begin
                    errors++;
                    $display("FAIL level cycle %0d: got %b expected %b", ncyc, level, e.level);
                end
                checks++;
                if (rise !== e.rise) begin
                    errors++;
                    $display("FAIL rise cycle %0d: got %b expected %b", ncyc, rise, e.rise);
                end
                checks++;
                if (fall !== e.fall) begin
                    errors++;
                    $display("FAIL fall cycle %0d: got %b expected %b", ncyc, fall, e.fall);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [CH-1:0] d;
        for (int c = 0; c < CH; c++) run[c] = 0;

        // Reset held with inputs high, then release and time the rise
        for (int k = 0; k < 3; k++) cycle(4'hF, 1'b1, 1'b0);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle(4'hF, 1'b1, 1'b1);
            @(posedge clk);
            #2;
            n = k;
            if (level == 4'hF) break;
        end
        checks++;
        if (n != SS + DB) begin
            errors++;
            $display("FAIL reset_release_latency: got %0d edges expected %0d", n, SS + DB);
        end
        hold(4'hF, 1'b1, 3);

        // Glitch rejection on channel 0, then a clean step
        for (int k = 0; k < 2; k++) cycle(4'h0, 1'b1, 1'b0);
        hold(4'h0, 1'b1, 4);
        hold(4'h1, 1'b1, 5);
        hold(4'h0, 1'b1, 15);
        hold(4'h1, 1'b1, 15);

        // Fall path on channel 2 while channel 0 stays high
        hold(4'h5, 1'b1, 15);
        hold(4'h1, 1'b1, 15);

        // Tick gating, with a mismatch cleared while tick is low
        for (int k = 0; k < 2; k++) cycle(4'h0, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) cycle(4'h2, (k % 4) == 0, 1'b1);
        hold(4'h0, 1'b0, 10);
        for (int k = 0; k < 50; k++) cycle(4'h2, (k % 4) == 0, 1'b1);

        // Simultaneous steps on several channels
        for (int k = 0; k < 2; k++) cycle(4'h0, 1'b1, 1'b0);
        hold(4'h0, 1'b1, 4);
        hold(4'hD, 1'b1, 15);

        // Reset in the middle of a count on channel 3
        for (int k = 0; k < 2; k++) cycle(4'h0, 1'b1, 1'b0);
        hold(4'h0, 1'b1, 4);
        hold(4'h8, 1'b1, 6);
        for (int k = 0; k < 2; k++) cycle(4'h8, 1'b1, 1'b0);
        hold(4'h8, 1'b1, 15);

        // Randomized: sparse input toggles, random tick, rare reset
        d = '0;
        for (int k = 0; k < 2000; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 9) == 0) d[c] = ~d[c];
            end
            cycle(d, $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
        end

        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
